// File: rtl/mcpu_dmem_arb.sv
// mcpu_dmem_arb
//   Round-robin arbiter and fixed-latency sequencer that shares one data
//   memory path between the two data-cache request ports of the core.
//   A granted request goes to on-chip RAM (paddr[29]=0) or to the MMIO
//   block (paddr[29]=1). Read data is captured into a register, and the
//   winning port receives a one-cycle done pulse.
//
// Parameters
//   RAM_AW : RAM word-address width. paddr bits above it (below bit 29) are
//            dropped, so the RAM aliases across the low half of the map.
//   LAT    : target read latency in cycles after the strobe cycle (1..4).
//
// Ports
//   clkrst_core_clk / clkrst_core_rst_n : clock, async active-low reset
//   mem2dc_*0 / mem2dc_*1               : requester ports (valid, paddr,
//                                         byte write enables, write data,
//                                         done pulse, read data)
//   ram_*                               : RAM port A (strobe, address,
//                                         byte enables, wdata, q)
//   mmio_*                              : MMIO block (strobe, address,
//                                         write enables, wdata, q)
//   arb_busy                            : high whenever not IDLE
module mcpu_dmem_arb #(
    parameter int RAM_AW = 14,
    parameter int LAT    = 1
) (
    input  logic              clkrst_core_clk,
    input  logic              clkrst_core_rst_n,

    input  logic              mem2dc_valid0,
    input  logic [29:0]       mem2dc_paddr0,
    input  logic [3:0]        mem2dc_write0,
    input  logic [31:0]       mem2dc_data_out0,
    output logic              mem2dc_done0,
    output logic [31:0]       mem2dc_data_in0,

    input  logic              mem2dc_valid1,
    input  logic [29:0]       mem2dc_paddr1,
    input  logic [3:0]        mem2dc_write1,
    input  logic [31:0]       mem2dc_data_out1,
    output logic              mem2dc_done1,
    output logic [31:0]       mem2dc_data_in1,

    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_q,

    output logic              mmio_en,
    output logic [28:0]       mmio_addr,
    output logic [3:0]        mmio_wren,
    output logic [31:0]       mmio_wdata,
    input  logic [31:0]       mmio_q,

    output logic              arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        rr_last_q, rr_last_d;
    logic        sel_mmio_q, sel_mmio_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    // Fields of the currently granted port; requesters hold them until done.
    logic [29:0] cur_paddr;
    logic [3:0]  cur_write;
    logic [31:0] cur_wdata;

    always_comb begin
        cur_paddr = gnt_q ? mem2dc_paddr1    : mem2dc_paddr0;
        cur_write = gnt_q ? mem2dc_write1    : mem2dc_write0;
        cur_wdata = gnt_q ? mem2dc_data_out1 : mem2dc_data_out0;
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 1'b0;
            rr_last_q  <= 1'b1;     // port 0 wins the first tie
            sel_mmio_q <= 1'b0;
            cnt_q      <= 2'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_last_q  <= rr_last_d;
            sel_mmio_q <= sel_mmio_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_last_d  = rr_last_q;
        sel_mmio_d = sel_mmio_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;

        ram_en     = 1'b0;
        ram_addr   = '0;
        ram_byteen = 4'd0;
        ram_wdata  = 32'd0;
        mmio_en    = 1'b0;
        mmio_addr  = 29'd0;
        mmio_wren  = 4'd0;
        mmio_wdata = 32'd0;
        mem2dc_done0 = 1'b0;
        mem2dc_done1 = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem2dc_valid0 || mem2dc_valid1) begin
                    // On a tie, the port that did not win last time goes.
                    gnt_d     = (mem2dc_valid0 && mem2dc_valid1) ? ~rr_last_q
                                                                 : mem2dc_valid1;
                    rr_last_d = gnt_d;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                sel_mmio_d = cur_paddr[29];
                if (cur_paddr[29]) begin
                    mmio_en    = 1'b1;
                    mmio_addr  = cur_paddr[28:0];
                    mmio_wren  = cur_write;
                    mmio_wdata = cur_wdata;
                end else begin
                    ram_en     = 1'b1;
                    ram_addr   = cur_paddr[RAM_AW-1:0];
                    ram_byteen = cur_write;
                    ram_wdata  = cur_wdata;
                end
                cnt_d   = 2'(LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter reaches 0 in the LAT-th wait cycle, when q is valid.
                if (cnt_q == 2'd0) begin
                    rdata_d = sel_mmio_q ? mmio_q : ram_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                mem2dc_done0 = ~gnt_q;
                mem2dc_done1 = gnt_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem2dc_data_in0 = rdata_q;
    assign mem2dc_data_in1 = rdata_q;
    assign arb_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mcpu_dmem_arb.sv
module tb_mcpu_dmem_arb;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-data sources change every cycle so the capture cycle is visible.
    logic [31:0] ram_q, mmio_q;
    assign ram_q  = {16'hDEAD, cyc[15:0]};
    assign mmio_q = {16'hB000, cyc[15:0]};

    // ---- LAT=1 instance ----
    logic        v0, v1, dn0, dn1, ram_en, mmio_en, busy;
    logic [29:0] pa0, pa1;
    logic [3:0]  wr0, wr1, ram_be, mmio_wren;
    logic [31:0] wd0, wd1, di0, di1, ram_wd, mmio_wd;
    logic [13:0] ram_addr;
    logic [28:0] mmio_addr;

    mcpu_dmem_arb #(.RAM_AW(14), .LAT(1)) u_dut (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
        .mem2dc_valid0(v0), .mem2dc_paddr0(pa0), .mem2dc_write0(wr0),
        .mem2dc_data_out0(wd0), .mem2dc_done0(dn0), .mem2dc_data_in0(di0),
        .mem2dc_valid1(v1), .mem2dc_paddr1(pa1), .mem2dc_write1(wr1),
        .mem2dc_data_out1(wd1), .mem2dc_done1(dn1), .mem2dc_data_in1(di1),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_byteen(ram_be),
        .ram_wdata(ram_wd), .ram_q(ram_q),
        .mmio_en(mmio_en), .mmio_addr(mmio_addr), .mmio_wren(mmio_wren),
        .mmio_wdata(mmio_wd), .mmio_q(mmio_q),
        .arb_busy(busy)
    );

    // ---- LAT=3 instance ----
    logic        v0_3, v1_3, dn0_3, dn1_3, ram_en_3, mmio_en_3, busy_3;
    logic [29:0] pa0_3, pa1_3;
    logic [31:0] di0_3, di1_3, ram_wd_3, mmio_wd_3;
    logic [3:0]  ram_be_3, mmio_wren_3;
    logic [13:0] ram_addr_3;
    logic [28:0] mmio_addr_3;

    mcpu_dmem_arb #(.RAM_AW(14), .LAT(3)) u_dut3 (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
        .mem2dc_valid0(v0_3), .mem2dc_paddr0(pa0_3), .mem2dc_write0(4'd0),
        .mem2dc_data_out0(32'd0), .mem2dc_done0(dn0_3), .mem2dc_data_in0(di0_3),
        .mem2dc_valid1(v1_3), .mem2dc_paddr1(pa1_3), .mem2dc_write1(4'd0),
        .mem2dc_data_out1(32'd0), .mem2dc_done1(dn1_3), .mem2dc_data_in1(di1_3),
        .ram_en(ram_en_3), .ram_addr(ram_addr_3), .ram_byteen(ram_be_3),
        .ram_wdata(ram_wd_3), .ram_q(ram_q),
        .mmio_en(mmio_en_3), .mmio_addr(mmio_addr_3), .mmio_wren(mmio_wren_3),
        .mmio_wdata(mmio_wd_3), .mmio_q(mmio_q),
        .arb_busy(busy_3)
    );

    // ---- scoreboard ----
    typedef struct {
        logic [1:0]  port_oh;   // {done1, done0}
        logic        chk_data;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        logic        mmio;
        logic [28:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } acc_t;

    done_t dq[$];
    done_t dq3[$];
    acc_t  aq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_done(input logic [1:0] oh, input logic cd, input logic [31:0] d, input int c);
        done_t e;
        e.port_oh = oh; e.chk_data = cd; e.data = d; e.cyc = c;
        dq.push_back(e);
    endtask

    task automatic push_acc(input logic m, input logic [28:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input int c);
        acc_t e;
        e.mmio = m; e.addr = a; e.be = be; e.wdata = wd; e.cyc = c;
        aq.push_back(e);
    endtask

    // Done / data monitor, LAT=1 instance
    always @(negedge clk) begin
        if (dn0 || dn1) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 64'({dn1, dn0}), 64'd0);
            end else begin
                done_t d;
                d = dq.pop_front();
                chk("done_port", 64'({dn1, dn0}), 64'(d.port_oh));
                chk("done_cycle", 64'(cyc), 64'(d.cyc));
                if (d.chk_data) begin
                    chk("data_in0", 64'(di0), 64'(d.data));
                    chk("data_in1", 64'(di1), 64'(d.data));
                end
            end
        end
    end

    // Access monitor, LAT=1 instance
    always @(negedge clk) begin
        if (ram_en || mmio_en) begin
            if (aq.size() == 0) begin
                chk("access_unexpected", 64'({ram_en, mmio_en}), 64'd0);
            end else begin
                acc_t a;
                a = aq.pop_front();
                chk("acc_cycle", 64'(cyc), 64'(a.cyc));
                chk("acc_en", 64'({ram_en, mmio_en}), a.mmio ? 64'b01 : 64'b10);
                if (a.mmio) begin
                    chk("mmio_addr", 64'(mmio_addr), 64'(a.addr));
                    chk("mmio_wren", 64'(mmio_wren), 64'(a.be));
                    chk("mmio_wdata", 64'(mmio_wd), 64'(a.wdata));
                end else begin
                    chk("ram_addr", 64'(ram_addr), 64'(a.addr[13:0]));
                    chk("ram_byteen", 64'(ram_be), 64'(a.be));
                    chk("ram_wdata", 64'(ram_wd), 64'(a.wdata));
                end
            end
        end else begin
            chk("idle_addr_be_zero", 64'({ram_addr, ram_be, mmio_addr, mmio_wren}), 64'd0);
            chk("idle_wdata_zero", {ram_wd, mmio_wd}, 64'd0);
        end
    end

    // Done / data monitor, LAT=3 instance
    always @(negedge clk) begin
        if (dn0_3 || dn1_3) begin
            if (dq3.size() == 0) begin
                chk("lat3_done_unexpected", 64'({dn1_3, dn0_3}), 64'd0);
            end else begin
                done_t d;
                d = dq3.pop_front();
                chk("lat3_done_port", 64'({dn1_3, dn0_3}), 64'(d.port_oh));
                chk("lat3_done_cycle", 64'(cyc), 64'(d.cyc));
                chk("lat3_data_in0", 64'(di0_3), 64'(d.data));
                chk("lat3_data_in1", 64'(di1_3), 64'(d.data));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // ---- stimulus ----
    initial begin
        int t0;
        done_t e3;
        rst_n = 1'b0;
        v0 = 0; v1 = 0; pa0 = 0; pa1 = 0; wr0 = 0; wr1 = 0; wd0 = 0; wd1 = 0;
        v0_3 = 0; v1_3 = 0; pa0_3 = 0; pa1_3 = 0;
        repeat (2) next();

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'({dn1, dn0}), 64'd0);
        chk("rst_en", 64'({ram_en, mmio_en}), 64'd0);
        chk("rst_data_in0", 64'(di0), 64'd0);
        rst_n = 1'b1;
        next();

        // Single RAM read from port 0
        t0 = cyc;
        v0 = 1; pa0 = 30'h0000_0010; wr0 = 4'h0;
        push_acc(1'b0, 29'h10, 4'h0, 32'h0, t0 + 1);
        push_done(2'b01, 1'b1, {16'hDEAD, 16'(t0 + 2)}, t0 + 3);
        next();
        chk("busy_access", 64'(busy), 64'd1);
        repeat (3) next();
        v0 = 0; pa0 = 0;
        next();

        // MMIO write from port 1; valid dropped after the grant
        t0 = cyc;
        v1 = 1; pa1 = 30'h2000_0004; wr1 = 4'hF; wd1 = 32'h55;
        push_acc(1'b1, 29'h4, 4'hF, 32'h55, t0 + 1);
        push_done(2'b10, 1'b0, 32'h0, t0 + 3);
        next();
        v1 = 0;
        repeat (3) next();
        pa1 = 0; wr1 = 0; wd1 = 0;
        next();

        // Both ports requesting continuously: grants alternate 0,1,0,1
        t0 = cyc;
        v0 = 1; pa0 = 30'h0000_0020;
        v1 = 1; pa1 = 30'h2000_0030;
        for (int k = 0; k < 4; k++) begin
            int t;
            t = t0 + 4 * k;
            if (k % 2 == 0) begin
                push_acc(1'b0, 29'h20, 4'h0, 32'h0, t + 1);
                push_done(2'b01, 1'b1, {16'hDEAD, 16'(t + 2)}, t + 3);
            end else begin
                push_acc(1'b1, 29'h30, 4'h0, 32'h0, t + 1);
                push_done(2'b10, 1'b1, {16'hB000, 16'(t + 2)}, t + 3);
            end
        end
        repeat (16) next();
        v0 = 0; v1 = 0; pa0 = 0; pa1 = 0;
        next();

        // Aliased RAM address
        t0 = cyc;
        v0 = 1; pa0 = 30'h0000_4008;
        push_acc(1'b0, 29'h8, 4'h0, 32'h0, t0 + 1);
        push_done(2'b01, 1'b1, {16'hDEAD, 16'(t0 + 2)}, t0 + 3);
        repeat (4) next();
        v0 = 0; pa0 = 0;
        next();

        // Reset while in WAIT: no done, outputs cleared immediately
        t0 = cyc;
        v0 = 1; pa0 = 30'h0000_0050;
        push_acc(1'b0, 29'h50, 4'h0, 32'h0, t0 + 1);
        repeat (2) next();
        chk("busy_wait", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_en", 64'({ram_en, mmio_en}), 64'd0);
        chk("midrst_done", 64'({dn1, dn0}), 64'd0);
        chk("midrst_data_in1", 64'(di1), 64'd0);
        v0 = 0; pa0 = 0;
        repeat (2) next();
        rst_n = 1'b1;
        next();

        // Tie right after reset: port 0 must win first
        t0 = cyc;
        v0 = 1; pa0 = 30'h0000_0060;
        v1 = 1; pa1 = 30'h0000_0070;
        push_acc(1'b0, 29'h60, 4'h0, 32'h0, t0 + 1);
        push_done(2'b01, 1'b1, {16'hDEAD, 16'(t0 + 2)}, t0 + 3);
        push_acc(1'b0, 29'h70, 4'h0, 32'h0, t0 + 5);
        push_done(2'b10, 1'b1, {16'hDEAD, 16'(t0 + 6)}, t0 + 7);
        repeat (4) next();
        v0 = 0; pa0 = 0;
        repeat (4) next();
        v1 = 0; pa1 = 0;
        next();

        // Fresh lone request on port 1
        t0 = cyc;
        v1 = 1; pa1 = 30'h0000_0044;
        push_acc(1'b0, 29'h44, 4'h0, 32'h0, t0 + 1);
        push_done(2'b10, 1'b1, {16'hDEAD, 16'(t0 + 2)}, t0 + 3);
        repeat (4) next();
        v1 = 0; pa1 = 0;
        next();

        // LAT=3: RAM read on port 0, then MMIO read on port 1
        t0 = cyc;
        v0_3 = 1; pa0_3 = 30'h0000_0100;
        e3.port_oh = 2'b01; e3.chk_data = 1'b1;
        e3.data = {16'hDEAD, 16'(t0 + 4)}; e3.cyc = t0 + 5;
        dq3.push_back(e3);
        next();
        v0_3 = 0;
        repeat (3) next();
        chk("lat3_busy_wait", 64'(busy_3), 64'd1);
        repeat (2) next();
        pa0_3 = 0;
        t0 = cyc;
        v1_3 = 1; pa1_3 = 30'h2000_0200;
        e3.port_oh = 2'b10; e3.chk_data = 1'b1;
        e3.data = {16'hB000, 16'(t0 + 4)}; e3.cyc = t0 + 5;
        dq3.push_back(e3);
        repeat (6) next();
        v1_3 = 0; pa1_3 = 0;

        repeat (5) next();
        chk("done_queue_empty", 64'(dq.size()), 64'd0);
        chk("acc_queue_empty", 64'(aq.size()), 64'd0);
        chk("lat3_queue_empty", 64'(dq3.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcpu_dmem_arb.md
# mcpu_dmem_arb

Round-robin arbiter and sequencer sharing one single-ported data memory path between the core's two data-cache ports (mem2dc port 0 and port 1). Each granted request is steered to on-chip RAM or the MMIO peripheral block by physical address bit 29. The block runs a fixed-latency access, captures read data, and returns a one-cycle done pulse to the winner. It sits between MCPU_core and the RAM port A / MCPU_SOC_mmio in the SoC top.

## Interface
- RAM_AW, 14: RAM word-address width; paddr bits above RAM_AW-1 (below bit 29) are ignored, so the RAM aliases.
- LAT, 1: read latency of RAM and MMIO, in cycles after the strobe cycle; legal 1..4.

- clkrst_core_clk  in  1  core clock; all state on rising edge.
- clkrst_core_rst_n  in  1  asynchronous, active-low reset.
- mem2dc_valid0 / mem2dc_valid1  in  1  request; held with its fields until done is sampled.
- mem2dc_paddr0 / mem2dc_paddr1  in  30  word address; bit 29 = MMIO.
- mem2dc_write0 / mem2dc_write1  in  4  byte write enables; 0 = read.
- mem2dc_data_out0 / mem2dc_data_out1  in  32  write data.
- mem2dc_done0 / mem2dc_done1  out  1  one-cycle completion pulse.
- mem2dc_data_in0 / mem2dc_data_in1  out  32  both driven from the captured read-data register.
- ram_en  out  1  RAM clock enable / strobe.
- ram_addr  out  RAM_AW  RAM word address.
- ram_byteen  out  4  RAM byte enables; nonzero = write.
- ram_wdata  out  32  RAM write data.
- ram_q  in  32  RAM read data.
- mmio_en  out  1  MMIO strobe.
- mmio_addr  out  29  MMIO address (paddr[28:0]).
- mmio_wren  out  4  MMIO byte write enables.
- mmio_wdata  out  32  MMIO write data.
- mmio_q  in  32  MMIO read data.
- arb_busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if no valid, stay. If exactly one port is valid, grant it. If both are valid, grant the port not equal to rr_last. Register gnt, set rr_last <= gnt, go to ACCESS.
- ACCESS (1 cycle):
  - Drive the granted port's fields to the selected target.
  - paddr[29]=0: ram_en=1, ram_addr=paddr[RAM_AW-1:0], ram_byteen=write, ram_wdata=data_out.
  - paddr[29]=1: mmio_en=1, mmio_addr=paddr[28:0], mmio_wren=write, mmio_wdata=data_out.
  - Register the selected target in sel_mmio. Load wait counter with LAT-1. Go to WAIT.
- WAIT: decrement the counter. When it is 0, capture rdata <= sel_mmio ? mmio_q : ram_q, then go to DONE. LAT=1 therefore spends exactly one cycle in WAIT.
- DONE (1 cycle): assert mem2dc_done[gnt]=1, present rdata on both data_in outputs, go to IDLE.
- Writes run the identical sequence. rdata is still captured; its value is don't-care for writes.
- Strobes and write enables are 0 outside ACCESS. Address and data outputs are 0 outside ACCESS.
- Requester that drops valid mid-transaction: the access still completes and done still pulses. No abort.
- Both ports requesting continuously: grants strictly alternate.
- A requester seeing done re-raises valid no earlier than the next cycle. IDLE treats that as a new request.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE, rr_last=1 (port 0 wins the first tie).
  - rdata=0, gnt=0, counter=0.
  - All done, strobe, enable and busy outputs are 0.
  - An in-flight access is abandoned with no done.
- Request seen in IDLE at cycle 0:
  - ACCESS at cycle 1.
  - WAIT at cycles 2..1+LAT.
  - done at cycle 2+LAT.
  - IDLE at cycle 3+LAT.
- Request-to-done latency is 2+LAT cycles. Transaction occupancy is 3+LAT cycles (4 cycles at LAT=1).
- Throughput is one transaction per 3+LAT cycles, regardless of requester or target.
- The losing requester waits at most one full transaction before being granted.
- data_in is stable from DONE until the next capture.

## Test plan
- Single read, LAT=1: valid0, paddr0=0x0000_0010, write0=0, ram_q=0xDEADBEEF in cycle 2 -> ram_en=1, ram_addr=0x10 in cycle 1; done0 pulses in cycle 3 with data_in0=0xDEADBEEF; done1 stays 0.
- MMIO write: valid1, paddr1=0x2000_0004, write1=0xF, data_out1=0x55 -> in ACCESS, mmio_en=1, mmio_addr=0x4, mmio_wren=0xF, mmio_wdata=0x55, ram_en=0; done1 pulses in cycle 3.
- Tie after reset: valid0 and valid1 raised in the same cycle and held until each sees done -> port 0 done in cycle 3, port 1 done in cycle 7; with both re-raising immediately, grant order continues 0,1,0,1.
- Latency parameter: LAT=3, one read -> WAIT lasts 3 cycles; done in cycle 5; the captured value equals ram_q in cycle 4.
- Reset mid-operation: assert rst_n=0 in WAIT -> all outputs 0 immediately; no done. After release, a fresh valid1 completes normally with port 1 granted.
- Aliasing: paddr0=0x0000_4008 with RAM_AW=14 -> ram_addr=0x0008, ram_en=1, mmio_en=0.
